alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single 16-bit add/sub ALU between two requesters (e.g. scalar core and vector/mem-address unit).
- Round-robin arbitration, valid/ready request and response channels, operand and result registers.
- Sits between the requesters and the ALU instance, driving its ALUop/srcA/srcB and sampling ALUresult.
- Non-pipelined: one transaction in flight.

Parameters:
- WIDTH, 16, operand/result width; must match the ALU datapath width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  arbiter accepts requester 0 this cycle.
- req0_op  in  2  00 = sub (a-b), 01 = add (a+b), 1x = illegal.
- req0_a  in  WIDTH  operand A.
- req0_b  in  WIDTH  operand B.
- rsp0_valid  out  1  result for requester 0 available.
- rsp0_ready  in  1  requester 0 consumes result.
- rsp0_result  out  WIDTH  result.
- rsp0_err  out  1  illegal op flag, qualified by rsp0_valid.
- req1_* / rsp1_*: identical set for requester 1.
- alu_op  out  2  to ALU ALUop.
- alu_srcA  out  WIDTH  to ALU srcA.
- alu_srcB  out  WIDTH  to ALU srcB.
- alu_result  in  WIDTH  from ALU ALUresult (combinational).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Single clock clk; rst is synchronous and active-high. All state updates occur on the rising clk edge.
- Reset values:
  - state = IDLE; all ready/valid/err/busy = 0; rsp results = 0.
  - op_q = 00; a_q = b_q = 0; owner = 0; last_grant = 1, so req0 wins first.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational. If exactly one reqN_valid is high, grant N. If both are high, grant the requester != last_grant.
  - Only the granted reqN_ready = 1; the other ready = 0. Ready is never asserted while busy.
  - On handshake (valid & ready): latch op, a, b into op_q/a_q/b_q; owner = N; go to EXEC.
  - With no valid, stay in IDLE.
- EXEC (one cycle):
  - alu_op/alu_srcA/alu_srcB = op_q/a_q/b_q. These ports are always driven from the registers, in every state.
  - At the cycle end, capture the result into the owner's rsp result register. If op_q[1] = 1, capture 0 and set err = 1; otherwise capture alu_result and set err = 0. X from the ALU must never reach the response registers.
  - Go to RESP.
- RESP:
  - rsp<owner>_valid = 1; the other rsp valid = 0. Result and err are held stable while valid & !ready.
  - On rsp<owner>_ready = 1: clear valid, set last_grant = owner, go to IDLE.
- Latency and throughput:
  - Request accepted in cycle N → rsp valid from cycle N+2.
  - If rsp_ready is already high, the next accept is possible at N+3, giving 1 op per 3 cycles max.
- Arithmetic: modulo 2^WIDTH. No carry, borrow or overflow outputs.
  - 0x0000 - 0x0001 = 0xFFFF.
  - 0xFFFF + 0x0001 = 0x0000.
- Requester changing op/a/b after acceptance has no effect on the in-flight operation.
- Non-owner valid during EXEC/RESP waits (ready = 0) and is not dropped. It wins the next IDLE arbitration because last_grant = owner.
- Reset mid-operation (EXEC or RESP): transaction discarded, no response issued, all outputs return to their reset values the following cycle.
- rsp_ready while rsp_valid = 0 is ignored.

Test Plan:
- Reset, then req0 add: req0_valid = 1, op = 01, a = 0x0003, b = 0x0004.
  - req0_ready = 1 in cycle N.
  - rsp0_valid = 1 with result 0x0007, err = 0 at N+2.
  - rsp1_valid stays 0.
- req1 sub wrap: a = 0x0000, b = 0x0001 → rsp1_result = 0xFFFF.
  - Then add 0xFFFF + 0x0001 → 0x0000.
- Both valid continuously right after reset, rsp_ready tied 1.
  - Grants alternate req0, req1, req0, req1.
  - Accepts occur at 3-cycle spacing; each response goes to the correct port.
- Backpressure: req0 op in flight with rsp0_ready = 0 for 5 cycles, req1_valid = 1 throughout.
  - rsp0_result held stable; req1_ready = 0 throughout.
  - After rsp0_ready = 1, req1 is granted in the next IDLE cycle.
- Illegal op: req0 op = 10, a = 0x1234, b = 0x0001 → rsp0_err = 1, rsp0_result = 0x0000.
  - Next legal op returns err = 0.
- rst asserted in RESP with rsp0_valid = 1.
  - Next cycle: rsp0_valid = 0, busy = 0.
  - With both valid afterwards, req0 is granted first.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles both requester channels and the ALU-facing bus
// shared by alu_arbiter.
//   req0_*/req1_* : request channel (valid/ready, op, a, b)
//   rsp0_*/rsp1_* : response channel (valid/ready, result, err)
//   alu_*         : operands to the ALU and its combinational result
// slave modport  : seen by the arbiter.
// master modport : seen by the requesters/ALU side.
interface alu_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_result;
  logic             rsp0_err;

  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_result;
  logic             rsp1_err;

  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_srcA;
  logic [WIDTH-1:0] alu_srcB;
  logic [WIDTH-1:0] alu_result;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    input  alu_result,
    output req0_ready, rsp0_valid, rsp0_result, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_result, rsp1_err,
    output alu_op, alu_srcA, alu_srcB
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    output alu_result,
    input  req0_ready, rsp0_valid, rsp0_result, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_result, rsp1_err,
    input  alu_op, alu_srcA, alu_srcB
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one add/sub ALU between two requesters with
// round-robin arbitration. One transaction in flight:
// IDLE (grant/accept) -> EXEC (ALU evaluates registered operands)
// -> RESP (hold result until the owner consumes it).
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : alu_arbiter_if.slave (request/response channels, ALU bus)
//   busy : high whenever the FSM is not in IDLE
module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             owner_reg;
  logic             last_grant_reg;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic             grant;
  logic             accept;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

  // Next state, grant and handshake outputs.
  always_comb begin
    state_next = state_reg;
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;
    grant      = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        // Ready is suppressed during reset so nothing is accepted then.
        if (!rst && (req_valid != 2'b00)) begin
          // Contention goes to whoever did not win last time.
          grant      = (req_valid == 2'b11) ? ~last_grant_reg : req_valid[1];
          req_ready  = grant ? 2'b10 : 2'b01;
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        rsp_valid = owner_reg ? 2'b10 : 2'b01;
        if (rsp_ready[owner_reg]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Operand, owner and round-robin history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg         <= 2'b00;
      a_reg          <= '0;
      b_reg          <= '0;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      if (accept) begin
        owner_reg <= grant;
        if (grant) begin
          op_reg <= bus.req1_op;
          a_reg  <= bus.req1_a;
          b_reg  <= bus.req1_b;
        end else begin
          op_reg <= bus.req0_op;
          a_reg  <= bus.req0_a;
          b_reg  <= bus.req0_b;
        end
      end
      if ((state_reg == RESP) && rsp_ready[owner_reg]) last_grant_reg <= owner_reg;
    end
  end

  // Per-requester response registers; only the owner's copy is written.
  // Illegal ops store zero, so the ALU output (possibly X) is never sampled.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    logic [WIDTH-1:0] result_reg;
    logic             err_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        result_reg <= '0;
        err_reg    <= 1'b0;
      end else if ((state_reg == EXEC) && (owner_reg == 1'(gi))) begin
        result_reg <= op_reg[1] ? '0 : bus.alu_result;
        err_reg    <= op_reg[1];
      end
    end
  end

  assign bus.req0_ready  = req_ready[0];
  assign bus.req1_ready  = req_ready[1];
  assign bus.rsp0_valid  = rsp_valid[0];
  assign bus.rsp1_valid  = rsp_valid[1];
  assign bus.rsp0_result = g_rsp[0].result_reg;
  assign bus.rsp1_result = g_rsp[1].result_reg;
  assign bus.rsp0_err    = g_rsp[0].err_reg;
  assign bus.rsp1_err    = g_rsp[1].err_reg;

  assign bus.alu_op   = op_reg;
  assign bus.alu_srcA = a_reg;
  assign bus.alu_srcB = b_reg;

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed test of alu_arbiter with a behavioural ALU.
module tb_alu_arbiter;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   n_checks = 0;
  int   n_fails  = 0;

  alu_arbiter_if #(.WIDTH(W)) bus ();

  alu_arbiter #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // ALU: illegal ops produce a junk value that must never be captured.
  always_comb begin
    if (bus.alu_op[1])      bus.alu_result = 16'hBEEF;
    else if (bus.alu_op[0]) bus.alu_result = bus.alu_srcA + bus.alu_srcB;
    else                    bus.alu_result = bus.alu_srcA - bus.alu_srcB;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input logic [1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic set_rsp_ready(input logic r0, input logic r1);
    bus.rsp0_ready = r0;
    bus.rsp1_ready = r1;
  endtask

  function automatic logic req_ready_of(input int n);
    return (n == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  function automatic logic rsp_valid_of(input int n);
    return (n == 0) ? bus.rsp0_valid : bus.rsp1_valid;
  endfunction

  function automatic logic [W-1:0] rsp_result_of(input int n);
    return (n == 0) ? bus.rsp0_result : bus.rsp1_result;
  endfunction

  function automatic logic rsp_err_of(input int n);
    return (n == 0) ? bus.rsp0_err : bus.rsp1_err;
  endfunction

  // One complete transaction from IDLE, only requester n active.
  task automatic single_op(input string tag, input int n, input logic [1:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_res, input logic exp_err);
    set_req(n, 1'b1, op, a, b);
    #1;
    check({tag, " req_ready"}, 32'(req_ready_of(n)), 32'd1);
    check({tag, " other req_ready"}, 32'(req_ready_of(1 - n)), 32'd0);
    tick();                                  // EXEC
    set_req(n, 1'b0, 2'b11, 16'hAAAA, 16'h5555);  // late changes must not matter
    #1;
    check({tag, " busy in EXEC"}, 32'(busy), 32'd1);
    check({tag, " alu_op"}, 32'(bus.alu_op), 32'(op));
    check({tag, " alu_srcA"}, 32'(bus.alu_srcA), 32'(a));
    check({tag, " alu_srcB"}, 32'(bus.alu_srcB), 32'(b));
    tick();                                  // RESP
    check({tag, " rsp_valid"}, 32'(rsp_valid_of(n)), 32'd1);
    check({tag, " other rsp_valid"}, 32'(rsp_valid_of(1 - n)), 32'd0);
    check({tag, " result"}, 32'(rsp_result_of(n)), 32'(exp_res));
    check({tag, " err"}, 32'(rsp_err_of(n)), 32'(exp_err));
    if (n == 0) set_rsp_ready(1'b1, 1'b0); else set_rsp_ready(1'b0, 1'b1);
    tick();                                  // back to IDLE
    check({tag, " rsp_valid cleared"}, 32'(rsp_valid_of(n)), 32'd0);
    check({tag, " busy cleared"}, 32'(busy), 32'd0);
    set_rsp_ready(1'b0, 1'b0);
    $display("txn %s: req%0d op=%b a=%h b=%h result=%h err=%b", tag, n, op, a, b,
             rsp_result_of(n), rsp_err_of(n));
  endtask

  initial begin
    set_req(0, 1'b0, 2'b00, '0, '0);
    set_req(1, 1'b0, 2'b00, '0, '0);
    set_rsp_ready(1'b0, 1'b0);

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset req0_ready", 32'(bus.req0_ready), 32'd0);
    check("reset req1_ready", 32'(bus.req1_ready), 32'd0);
    check("reset rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    check("reset rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    check("reset rsp0_result", 32'(bus.rsp0_result), 32'd0);
    check("reset rsp1_err", 32'(bus.rsp1_err), 32'd0);
    check("reset alu_op", 32'(bus.alu_op), 32'd0);
    check("reset alu_srcA", 32'(bus.alu_srcA), 32'd0);

    // Single-requester transactions
    single_op("add0",     0, 2'b01, 16'h0003, 16'h0004, 16'h0007, 1'b0);
    single_op("subwrap1", 1, 2'b00, 16'h0000, 16'h0001, 16'hFFFF, 1'b0);
    single_op("addwrap1", 1, 2'b01, 16'hFFFF, 16'h0001, 16'h0000, 1'b0);
    single_op("illegal0", 0, 2'b10, 16'h1234, 16'h0001, 16'h0000, 1'b1);
    single_op("legal0",   0, 2'b01, 16'h1234, 16'h0001, 16'h1235, 1'b0);

    // Reset while the response is pending (last winner was req0)
    set_req(0, 1'b1, 2'b01, 16'h0005, 16'h0005);
    tick();                                  // EXEC
    set_req(0, 1'b0, 2'b01, 16'h0005, 16'h0005);
    tick();                                  // RESP
    check("pre-reset rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
    check("pre-reset rsp0_result", 32'(bus.rsp0_result), 32'h000A);
    rst = 1'b1;
    tick();
    check("midrst rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst rsp0_result", 32'(bus.rsp0_result), 32'd0);
    check("midrst alu_srcA", 32'(bus.alu_srcA), 32'd0);
    $display("txn midrst: req0 op=01 a=0005 b=0005 discarded by reset");
    rst = 1'b0;

    // Both valid continuously, responses consumed at once: req0 first, then alternate
    set_req(0, 1'b1, 2'b01, 16'h000A, 16'h0001);   // 0x000B
    set_req(1, 1'b1, 2'b00, 16'h000A, 16'h0001);   // 0x0009
    set_rsp_ready(1'b1, 1'b1);
    for (int k = 0; k < 12; k++) begin
      int g;
      #1;
      g = (k / 3) % 2;
      case (k % 3)
        0: begin
          check($sformatf("rr%0d granted ready", k), 32'(req_ready_of(g)), 32'd1);
          check($sformatf("rr%0d other ready", k), 32'(req_ready_of(1 - g)), 32'd0);
        end
        1: begin
          check($sformatf("rr%0d busy", k), 32'(busy), 32'd1);
          check($sformatf("rr%0d readys", k), 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
        end
        default: begin
          check($sformatf("rr%0d rsp_valid", k), 32'(rsp_valid_of(g)), 32'd1);
          check($sformatf("rr%0d other rsp_valid", k), 32'(rsp_valid_of(1 - g)), 32'd0);
          check($sformatf("rr%0d result", k), 32'(rsp_result_of(g)),
                (g == 0) ? 32'h000B : 32'h0009);
          $display("txn rr%0d: req%0d result=%h", k, g, rsp_result_of(g));
        end
      endcase
      @(posedge clk);
    end
    #1;

    // Backpressure: req0 response held, req1 waiting throughout
    set_rsp_ready(1'b0, 1'b0);
    set_req(0, 1'b1, 2'b01, 16'h0100, 16'h0023);   // 0x0123
    set_req(1, 1'b1, 2'b00, 16'h0050, 16'h0008);   // 0x0048
    #1;
    check("bp req0_ready", 32'(bus.req0_ready), 32'd1);
    check("bp req1_ready idle", 32'(bus.req1_ready), 32'd0);
    tick();                                  // EXEC
    set_req(0, 1'b0, 2'b01, 16'h0100, 16'h0023);
    #1;
    check("bp req1_ready exec", 32'(bus.req1_ready), 32'd0);
    tick();                                  // RESP
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp hold%0d rsp0_valid", i), 32'(bus.rsp0_valid), 32'd1);
      check($sformatf("bp hold%0d rsp0_result", i), 32'(bus.rsp0_result), 32'h0123);
      check($sformatf("bp hold%0d req1_ready", i), 32'(bus.req1_ready), 32'd0);
      tick();
    end
    set_rsp_ready(1'b1, 1'b0);
    #1;
    check("bp release req1_ready", 32'(bus.req1_ready), 32'd0);
    tick();                                  // IDLE
    check("bp after rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    check("bp after req1_ready", 32'(bus.req1_ready), 32'd1);
    check("bp after req0_ready", 32'(bus.req0_ready), 32'd0);
    $display("txn bp0: req0 result=%h after backpressure", bus.rsp0_result);
    set_rsp_ready(1'b0, 1'b1);
    tick();                                  // EXEC
    set_req(1, 1'b0, 2'b00, 16'h0050, 16'h0008);
    tick();                                  // RESP
    check("bp req1 rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
    check("bp req1 result", 32'(bus.rsp1_result), 32'h0048);
    check("bp req1 err", 32'(bus.rsp1_err), 32'd0);
    $display("txn bp1: req1 result=%h", bus.rsp1_result);
    tick();
    check("final busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
